// File: rtl/req_ack_sender.sv
// Four-phase req/ack transmitter: holds a captured word on data_out and walks req through
// req-up, ack-up, req-down, ack-down, with an optional timeout against a dead responder.
module req_ack_sender #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             send,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             req,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack
);

  typedef enum logic [1:0] {StIdle, StReqHi, StReqLo} state_e;

  state_e             state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic               ack_s;
  logic               req_q, req_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               timed_out_q, timed_out_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               cnt_clr, cnt_en, expire;

  // ack is asynchronous to clk; only the last stage is ever looked at
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack};
    end
  end

  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  if (TIMEOUT_CYCLES != 0) begin : g_timeout
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_next;

    always_comb begin
      cnt_next = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_en) begin
        cnt_q <= cnt_next;
      end
    end

    // Looking at the incremented value makes req stay high exactly TIMEOUT_CYCLES cycles
    assign expire = (cnt_next >= CntLimit);
  end else begin : g_no_timeout
    logic unused_cnt;
    assign unused_cnt = cnt_clr ^ cnt_en;
    assign expire     = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    data_d      = data_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    timed_out_d = timed_out_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    busy        = 1'b1;
    unique case (state_q)
      StIdle: begin
        // A stale acknowledge from the last handshake blocks a new start
        busy  = ack_s;
        req_d = 1'b0;
        if (send && !ack_s) begin
          data_d      = data_in;
          req_d       = 1'b1;
          cnt_clr     = 1'b1;
          timed_out_d = 1'b0;
          state_d     = StReqHi;
        end
      end
      StReqHi: begin
        cnt_en = 1'b1;
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = StReqLo;
        end else if (expire) begin
          req_d       = 1'b0;
          timeout_d   = 1'b1;
          timed_out_d = 1'b1;
          state_d     = StReqLo;
        end
      end
      StReqLo: begin
        if (!ack_s) begin
          done_d  = !timed_out_q;
          state_d = StIdle;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      data_q      <= data_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign req      = req_q;
  assign data_out = data_q;
  assign done     = done_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_req_ack_sender.sv
// Directed bench for req_ack_sender: loopback, busy rejection, stale ack, timeout and
// mid-handshake reset, with a scoreboard of words expected at each done pulse.
module tb_req_ack_sender;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       send, send_to;
  logic [7:0] data_in;
  logic       loop_en, ack_force, ack, ack_to;
  logic       busy, done, timeout, req;
  logic [7:0] data_out;
  logic       busy_to, done_to, timeout_to, req_to;
  logic [7:0] data_out_to;

  int n_total = 0;
  int n_pass  = 0;
  int done_cnt = 0;
  int to_cnt   = 0;
  int d0, t0, hi;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign ack = loop_en ? req : ack_force;

  req_ack_sender u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .send     (send),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .req      (req),
    .data_out (data_out),
    .ack      (ack)
  );

  req_ack_sender #(.TIMEOUT_CYCLES(16)) u_dut_to (
    .clk      (clk),
    .reset_n  (reset_n),
    .send     (send_to),
    .data_in  (data_in),
    .busy     (busy_to),
    .done     (done_to),
    .timeout  (timeout_to),
    .req      (req_to),
    .data_out (data_out_to),
    .ack      (ack_to)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = done;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // Scoreboard: every done pulse must present the oldest outstanding word
  always begin
    @(posedge clk);
    #1;
    if (timeout) to_cnt++;
    if (done) begin
      done_cnt++;
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; send = 1'b0; send_to = 1'b0; data_in = 8'h00;
    loop_en = 1'b0; ack_force = 1'b0; ack_to = 1'b0;
    step();

    // Reset held: outputs stay cleared whatever the inputs do
    for (int i = 0; i < 4; i++) begin
      ack_force = i[0];
      send      = ~i[0];
      send_to   = 1'b1;
      data_in   = 8'(8'hF0 + i);
      step();
      check("rst_req", 32'(req), 32'd0);
      check("rst_data", 32'(data_out), 32'd0);
      check("rst_done_to", 32'(done | timeout), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    check("rst_req_to", 32'(req_to), 32'd0);
    send = 1'b0; send_to = 1'b0; ack_force = 1'b0; data_in = 8'h00;
    reset_n = 1'b1;
    step(); step();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_req", 32'(req), 32'd0);

    // Loopback: A5 then 3C accepted at E7
    loop_en = 1'b1;
    data_in = 8'hA5; send = 1'b1; exp_q.push_back(8'hA5);
    step();                               // E0
    send = 1'b0; data_in = 8'h00;
    check("lb_req_e0", 32'(req), 32'd1);
    check("lb_data_e0", 32'(data_out), 32'hA5);
    check("lb_busy_e0", 32'(busy), 32'd1);
    step(); check("lb_req_e1", 32'(req), 32'd1);
    step(); check("lb_req_e2", 32'(req), 32'd1);
    step(); check("lb_req_e3", 32'(req), 32'd0);
    step(); step();                       // E5
    check("lb_done_e5", 32'(done), 32'd0);
    check("lb_busy_e5", 32'(busy), 32'd1);
    step();                               // E6
    check("lb_done_e6", 32'(done), 32'd1);
    check("lb_busy_e6", 32'(busy), 32'd0);
    data_in = 8'h3C; send = 1'b1; exp_q.push_back(8'h3C);
    step();                               // E7
    send = 1'b0;
    check("lb_req_e7", 32'(req), 32'd1);
    check("lb_data_e7", 32'(data_out), 32'h3C);
    check("lb_done_e7", 32'(done), 32'd0);
    wait_done("lb2_done");

    // Busy rejection
    step();
    d0 = done_cnt;
    data_in = 8'h11; send = 1'b1; exp_q.push_back(8'h11);
    step();
    data_in = 8'h22;
    for (int i = 0; i < 5; i++) begin
      step();
      check("busy_hold_data", 32'(data_out), 32'h11);
    end
    send = 1'b0;
    repeat (10) step();
    check("busy_one_done", 32'(done_cnt - d0), 32'd1);
    check("busy_final_data", 32'(data_out), 32'h11);
    check("busy_final_req", 32'(req), 32'd0);

    // Stale ack in idle
    loop_en = 1'b0; ack_force = 1'b1;
    repeat (3) step();
    check("stale_busy", 32'(busy), 32'd1);
    d0 = done_cnt;
    data_in = 8'h44; send = 1'b1;
    step();
    send = 1'b0;
    check("stale_req", 32'(req), 32'd0);
    check("stale_data", 32'(data_out), 32'h11);
    repeat (3) step();
    check("stale_req_later", 32'(req), 32'd0);
    ack_force = 1'b0;
    step(); check("stale_busy_1", 32'(busy), 32'd1);
    step(); check("stale_busy_2", 32'(busy), 32'd0);
    loop_en = 1'b1;
    data_in = 8'h55; send = 1'b1; exp_q.push_back(8'h55);
    step();
    send = 1'b0;
    wait_done("stale_recover_done");
    step();
    check("stale_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Timeout with ack stuck low
    data_in = 8'h77; send_to = 1'b1;
    step();
    send_to = 1'b0;
    check("to_req_e0", 32'(req_to), 32'd1);
    check("to_data", 32'(data_out_to), 32'h77);
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!req_to) break;
      hi++;
    end
    check("to_req_high_cycles", 32'(hi), 32'd16);
    check("to_pulse", 32'(timeout_to), 32'd1);
    check("to_busy_pulse", 32'(busy_to), 32'd1);
    check("to_no_done", 32'(done_to), 32'd0);
    step();
    check("to_pulse_end", 32'(timeout_to), 32'd0);
    check("to_busy_low", 32'(busy_to), 32'd0);
    check("to_no_done_2", 32'(done_to), 32'd0);

    // Reset while in REQ_HI with ack high
    loop_en = 1'b0; ack_force = 1'b0;
    d0 = done_cnt; t0 = to_cnt;
    data_in = 8'h66; send = 1'b1;
    step();
    send = 1'b0;
    check("mr_req_e0", 32'(req), 32'd1);
    ack_force = 1'b1;
    step();
    check("mr_req_e1", 32'(req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mr_req_async", 32'(req), 32'd0);
    check("mr_busy_rst", 32'(busy), 32'd0);
    check("mr_data_rst", 32'(data_out), 32'd0);
    step(); step();
    reset_n = 1'b1;
    repeat (3) step();
    check("mr_busy_stale", 32'(busy), 32'd1);
    ack_force = 1'b0;
    step(); check("mr_busy_1", 32'(busy), 32'd1);
    step(); check("mr_busy_2", 32'(busy), 32'd0);
    repeat (3) step();
    check("mr_no_done", 32'(done_cnt - d0), 32'd0);
    check("mr_no_timeout", 32'(to_cnt - t0), 32'd0);
    check("mr_req_idle", 32'(req), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/req_ack_sender.md
# req_ack_sender

Four-phase request/acknowledge transmitter: the sending end of an asynchronous edge/level handshake whose receiving end traps and synchronizes our `req` in a foreign clock domain. It accepts a one-cycle `send` strobe with a data word in the `clk` domain. It then holds the word stable on `data_out` and drives `req` through a full req↑ ack↑ req↓ ack↓ cycle. The asynchronous `ack` return is synchronized internally, and an optional timeout stops the block hanging on a dead responder.

## Interface
- `WIDTH`, 8: data word width, ≥1.
- `SYNC_STAGES`, 2: synchronizer flops on `ack`, ≥2.
- `TIMEOUT_CYCLES`, 0: maximum `clk` cycles `req` stays high without `ack`; 0 disables the timeout.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `send`  in  1  start strobe; sampled only when `busy`=0.
- `data_in`  in  WIDTH  word captured on an accepted `send`.
- `busy`  out  1  high whenever a new `send` would be ignored.
- `done`  out  1  one-cycle pulse on successful handshake completion.
- `timeout`  out  1  one-cycle pulse when the handshake is abandoned.
- `req`  out  1  registered request level to the far domain.
- `data_out`  out  WIDTH  registered word; stable from `req`↑ until `done`/`timeout`.
- `ack`  in  1  asynchronous acknowledge from the far domain.

## Operation
- `ack` passes through a chain of `SYNC_STAGES` flops clocked by `clk`. Its last stage is `ack_s`, and only `ack_s` is used.
- FSM states are IDLE, REQ_HI and REQ_LO.
- IDLE: `req`=0. `busy` = `ack_s`, so the block refuses to start while a stale acknowledge is still high. If `send`=1 and `ack_s`=0, then on the next edge: `data_out`←`data_in`, `req`←1, the timeout counter clears, and the state goes to REQ_HI.
- REQ_HI: `busy`=1 and `req`=1. The counter increments every cycle.
  - If `ack_s`=1, then on the next edge `req`←0 and the state goes to REQ_LO.
  - Else if `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES`, then on the next edge `req`←0, `timeout` pulses for 1 cycle, and the state goes to REQ_LO.
  - `ack_s` takes priority over a same-cycle timeout expiry.
- REQ_LO: `busy`=1 and `req`=0. When `ack_s`=0, on the next edge the state goes to IDLE. `done` pulses for 1 cycle, but only if this handshake did not time out.
- `send` while `busy`=1 is ignored, with no queuing. Changes on `data_in` while busy do not affect `data_out`.
- Counter width is $clog2(`TIMEOUT_CYCLES`+1), saturating at its maximum value. It is absent when `TIMEOUT_CYCLES`=0.
- `ack` rising in IDLE or REQ_LO is spurious and only affects `busy`. `ack` falling in REQ_HI is ignored.

## Timing
- Reset (`reset_n`=0, asynchronous): state goes to IDLE, and `req`, `done`, `timeout`, `data_out` and all synchronizer flops go to 0. `busy` is 0 while in reset.
- Reset mid-handshake: `req` drops immediately without waiting for `ack`. After release, `busy` follows `ack_s`.
- `req` and `data_out` are driven directly from flops, with no combinational path from `ack`.
- Cycle numbering: E0 is the edge that samples `send`; `req` rises after E0.
- Loopback latency (`ack`=`req`, `SYNC_STAGES`=2): `ack_s` rises after E2. At E3, `req` falls. `ack_s` falls after E5. At E6, `done`=1 and `busy`=0. So `req` is high for 3 cycles and a new `send` is accepted at E7.
- In general, `req` high time is the responder delay + `SYNC_STAGES` + 1 cycles.
- Timeout with `ack` stuck low: `req` is high for exactly `TIMEOUT_CYCLES` cycles. `timeout` is high in the first cycle `req` is low, and `busy` drops one cycle later.
- `done` and `timeout` are never asserted in the same cycle.

## Test plan
- Reset values: hold `reset_n`=0, toggle `ack` and `send` → `req`, `done`, `timeout` and `data_out` all stay 0; state is IDLE after release.
- Loopback: `data_in`=8'hA5, `send` pulse, `ack`=`req` → `data_out`=A5 with `req` high for 3 cycles; `done` pulse at E6; second word 8'h3C is accepted at E7.
- Busy rejection: `send` with 8'h11, then further `send` pulses with 8'h22 during the handshake → one handshake only, `data_out` stays 11, exactly one `done`.
- Timeout: `TIMEOUT_CYCLES`=16, `ack` held 0 → `req` high 16 cycles, one `timeout` pulse, no `done`, `busy` low one cycle later.
- Stale ack: `ack` held 1 in IDLE, `send` pulsed → `busy`=1 and `req` stays 0. Lower `ack`, then pulse `send` → normal handshake completes.
- Reset mid-operation: assert `reset_n`=0 while in REQ_HI with `ack` high → `req` goes to 0 immediately. Release, lower `ack` → `busy` clears after 2 cycles, and no `done` or `timeout` is emitted.
